// File: rtl/shift_rows_serial_pkg.sv
// Shared AES constants, output FSM states and the ShiftRows index map.
// The same index helper serves the forward and inverse ShiftRows blocks.
package shift_rows_serial_pkg;

  localparam int AES_BLOCK_BYTES = 16;
  localparam int AES_ROWS        = 4;

  typedef enum logic {
    S_IDLE,
    S_STREAM
  } sr_state_e;

  // Source byte for output (r,c); inv selects InvShiftRows.
  function automatic logic [3:0] sr_src_idx(
    input logic [1:0] r,
    input logic [1:0] c,
    input logic       inv
  );
    logic [1:0] sc;
    sc = inv ? (c - r) : (c + r);
    return {sc, r};
  endfunction

endpackage

// File: rtl/shift_rows_serial_bank.sv
// 16x8 register bank: one write port, one combinational read port.
// Contents are deliberately not reset.
module sr_bank
  import shift_rows_serial_pkg::*;
#(
  parameter int NBYTES = AES_BLOCK_BYTES
) (
  input  logic       clock,
  input  logic       i_we,
  input  logic [3:0] i_waddr,
  input  logic [7:0] i_wdata,
  input  logic [3:0] i_raddr,
  output logic [7:0] o_rdata
);

  logic [7:0] r_mem [NBYTES];

  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/shift_rows_serial.sv
// Byte-serial AES ShiftRows with ping-pong input banks.
// One bank fills while the other streams out in ShiftRows order.
module shift_rows_serial
  import shift_rows_serial_pkg::*;
#(
  parameter int NBYTES = AES_BLOCK_BYTES
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       in_valid,
  input  logic [7:0] inbyte,
  output logic [7:0] outbyte,
  output logic       out_valid,
  output logic       out_last
);

  logic [3:0] r_wr_cnt;
  logic       r_wr_sel;
  logic [3:0] r_rd_cnt;
  logic       r_rd_sel;
  sr_state_e  r_state;

  logic       w_accept;
  logic       w_handoff;
  logic [3:0] w_raddr;
  logic [7:0] w_rdata0;
  logic [7:0] w_rdata1;
  logic [7:0] w_rdata;

  assign w_accept  = in_valid & ~clear;
  assign w_handoff = w_accept & (r_wr_cnt == 4'd15);
  assign w_raddr   = sr_src_idx(r_rd_cnt[1:0],
                                r_rd_cnt[3:2], 1'b0);
  assign w_rdata   = r_rd_sel ? w_rdata1 : w_rdata0;

  sr_bank #(.NBYTES(NBYTES)) u_bank0 (
    .clock   (clock),
    .i_we    (w_accept & ~r_wr_sel),
    .i_waddr (r_wr_cnt),
    .i_wdata (inbyte),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata0)
  );

  sr_bank #(.NBYTES(NBYTES)) u_bank1 (
    .clock   (clock),
    .i_we    (w_accept & r_wr_sel),
    .i_waddr (r_wr_cnt),
    .i_wdata (inbyte),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata1)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_cnt <= 4'd0;
      r_wr_sel <= 1'b0;
    end else if (clear) begin
      r_wr_cnt <= 4'd0;
    end else if (in_valid) begin
      r_wr_cnt <= r_wr_cnt + 4'd1;
      if (r_wr_cnt == 4'd15) r_wr_sel <= ~r_wr_sel;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_rd_cnt  <= 4'd0;
      r_rd_sel  <= 1'b0;
      outbyte   <= 8'd0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          outbyte   <= 8'd0;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          if (w_handoff) begin
            r_state  <= S_STREAM;
            r_rd_cnt <= 4'd0;
            r_rd_sel <= r_wr_sel;
          end
        end
        S_STREAM: begin
          outbyte   <= w_rdata;
          out_valid <= 1'b1;
          out_last  <= (r_rd_cnt == 4'd15);
          r_rd_cnt  <= r_rd_cnt + 4'd1;
          // A handoff on the last byte chains the next block gaplessly.
          if (r_rd_cnt == 4'd15) begin
            if (w_handoff) r_rd_sel <= r_wr_sel;
            else           r_state  <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_rows_serial.sv
// Directed self-checking bench for shift_rows_serial.
module tb_shift_rows_serial;

  logic       clock = 1'b0;
  logic       reset;
  logic       clear;
  logic       in_valid;
  logic [7:0] inbyte;
  logic [7:0] outbyte;
  logic       out_valid;
  logic       out_last;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int cap;

  logic [7:0] q_d[$];
  bit         q_l[$];
  int         q_c[$];

  logic [7:0] fips_in [16] = '{
    8'h19, 8'h3d, 8'he3, 8'hbe, 8'ha0, 8'hf4, 8'he2, 8'h2b,
    8'h9a, 8'hc6, 8'h8d, 8'h2a, 8'he9, 8'hf8, 8'h48, 8'h08};
  logic [7:0] fips_out[16] = '{
    8'h19, 8'hf4, 8'h8d, 8'h08, 8'ha0, 8'hc6, 8'h48, 8'hbe,
    8'h9a, 8'hf8, 8'he3, 8'h2b, 8'he9, 8'h3d, 8'he2, 8'h2a};
  logic [7:0] cnt_out [16] = '{
    8'h00, 8'h05, 8'h0a, 8'h0f, 8'h04, 8'h09, 8'h0e, 8'h03,
    8'h08, 8'h0d, 8'h02, 8'h07, 8'h0c, 8'h01, 8'h06, 8'h0b};

  shift_rows_serial #(.NBYTES(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .inbyte    (inbyte),
    .outbyte   (outbyte),
    .out_valid (out_valid),
    .out_last  (out_last)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (out_valid === 1'b1) begin
      q_d.push_back(outbyte);
      q_l.push_back(out_last);
      q_c.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $error("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v,
                       input logic [7:0] b,
                       input logic clr);
    in_valid = v;
    inbyte   = b;
    clear    = clr;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    inbyte   = 8'h00;
    clear    = 1'b0;
  endtask

  task automatic send_blk(input int sel,
                          input bit gaps,
                          output int c15);
    c15 = 0;
    for (int i = 0; i < 16; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) drive(1'b0, 8'h00, 1'b0);
      drive(1'b1, (sel != 0) ? 8'(i) : fips_in[i], 1'b0);
      c15 = cyc;
    end
  endtask

  task automatic wait_n(input int n);
    int k = 0;
    while (q_d.size() < n && k < 300) begin
      @(negedge clock);
      #1;
      k++;
    end
    chk("outcount", q_d.size(), n);
  endtask

  task automatic check_blk(input int base,
                           input int sel,
                           input string tag);
    logic [7:0] e;
    for (int i = 0; i < 16; i++) begin
      e = (sel != 0) ? cnt_out[i] : fips_out[i];
      chk({tag, "_data"}, q_d[base+i], e);
      chk({tag, "_last"}, q_l[base+i], i == 15);
      if (i > 0) chk({tag, "_gap"}, q_c[base+i], q_c[base] + i);
    end
  endtask

  task automatic flush();
    q_d.delete();
    q_l.delete();
    q_c.delete();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_vld"}, out_valid, 0);
    chk({tag, "_byte"}, outbyte, 0);
    chk({tag, "_last"}, out_last, 0);
  endtask

  initial begin
    reset    = 1'b1;
    clear    = 1'b0;
    in_valid = 1'b0;
    inbyte   = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    chk_idle("rst");
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk_idle("post_rst");

    flush();
    send_blk(0, 1'b0, cap);
    wait_n(16);
    chk("fips_lat", q_c[0], cap + 1);
    check_blk(0, 0, "fips");
    repeat (3) @(posedge clock);
    #1;
    chk_idle("idle1");
    chk("fips_extra", q_d.size(), 16);

    flush();
    send_blk(1, 1'b0, cap);
    wait_n(16);
    chk("cnt_lat", q_c[0], cap + 1);
    check_blk(0, 1, "cnt");

    flush();
    send_blk(0, 1'b0, cap);
    send_blk(1, 1'b0, cap);
    send_blk(0, 1'b0, cap);
    wait_n(48);
    check_blk(0, 0, "b2b0");
    check_blk(16, 1, "b2b1");
    check_blk(32, 0, "b2b2");
    chk("b2b_run", q_c[47], q_c[0] + 47);
    chk("b2b_lat", q_c[32], cap + 1);

    flush();
    send_blk(0, 1'b1, cap);
    send_blk(1, 1'b1, cap);
    wait_n(32);
    check_blk(0, 0, "gap0");
    check_blk(16, 1, "gap1");
    chk("gap_lat", q_c[16], cap + 1);

    flush();
    for (int i = 0; i < 7; i++) drive(1'b1, 8'ha0 + 8'(i), 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b1, 8'h55, 1'b1);
    send_blk(1, 1'b0, cap);
    wait_n(16);
    chk("clr_lat", q_c[0], cap + 1);
    check_blk(0, 1, "clr");
    repeat (20) @(posedge clock);
    #1;
    chk("clr_extra", q_d.size(), 16);

    flush();
    send_blk(0, 1'b0, cap);
    wait_n(7);
    chk("mid_vld", out_valid, 1);
    reset = 1'b1;
    #1;
    chk_idle("async_rst");
    #2;
    reset = 1'b0;
    repeat (20) @(posedge clock);
    #1;
    chk("rst_extra", q_d.size(), 7);
    chk_idle("rst_idle");
    flush();
    send_blk(1, 1'b0, cap);
    wait_n(16);
    chk("rec_lat", q_c[0], cap + 1);
    check_blk(0, 1, "rec");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/shift_rows_serial.md
SHIFT_ROWS_SERIAL -- requirements
Module: shift_rows_serial

Interface
REQ-001 SHALL have parameter NBYTES, default 16, meaning bytes per AES block; only 16 is supported.
REQ-002 SHALL have port clock  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port clear  input  1  synchronous abort of the partially received input block.
REQ-005 SHALL have port in_valid  input  1  inbyte is valid this cycle.
REQ-006 SHALL have port inbyte  input  8  input state byte, column-major order (index i = row i%4, col i/4).
REQ-007 SHALL have port outbyte  output  8  ShiftRows output byte, column-major order.
REQ-008 SHALL have port out_valid  output  1  outbyte is valid this cycle.
REQ-009 SHALL have port out_last  output  1  high with the 16th output byte of a block.

Function
REQ-010 SHALL implement forward AES ShiftRows: out[4c+r] = in[4*((c+r) mod 4)+r], with r, c in 0..3.
REQ-011 SHALL capture inbyte into the write bank at index wr_cnt on every cycle where in_valid=1, then increment wr_cnt (4 bits, wraps 15->0).
REQ-012 SHALL accept gaps in in_valid; wr_cnt holds while in_valid=0.
REQ-013 SHALL hold two 16-byte banks (ping-pong); capturing byte 15 SHALL hand the write bank to the output side and toggle the write-bank pointer in the same edge.
REQ-014 SHALL run an output FSM with states IDLE and STREAM: IDLE->STREAM on a bank handoff; STREAM->IDLE after byte 15 unless a handoff occurs in that same cycle, in which case STREAM continues with rd_cnt=0.
REQ-015 SHALL register outputs: on the edge following capture of input byte 15, outbyte = out[0] and out_valid=1; one byte per cycle thereafter, with no output gaps within a block.
REQ-016 SHALL assert out_last only together with out[15]; out_valid=0 and outbyte=0 while IDLE.
REQ-017 SHALL sustain back-to-back blocks at 1 byte/cycle input with continuous output; the two banks guarantee no overrun, and no backpressure port exists.
REQ-018 SHALL, on clear=1, reset wr_cnt to 0 and discard the partial block; an output block already streaming completes unaffected.
REQ-019 SHALL give clear priority over in_valid in the same cycle; the inbyte presented in that cycle is dropped.

Reset
REQ-020 SHALL, on reset=1 at any time including mid-block or mid-stream, asynchronously force outbyte=0, out_valid=0, out_last=0, wr_cnt=0, rd_cnt=0, bank pointer=0, and FSM=IDLE.
REQ-021 SHALL leave bank contents undefined after reset, and SHALL never present them on the output before a new complete block arrives.
REQ-022 SHALL resume normal operation on the first rising edge after reset deasserts.

Structure
REQ-023 SHALL take the shared AES package constants AES_BLOCK_BYTES=16 and AES_ROWS=4, plus the shift-index function (r,c)->source index; the forward and inverse ShiftRows blocks both use it.
REQ-024 SHALL instantiate one sub-module, sr_bank (a 16x8 register bank with write port and combinational read-index port), twice.

Verification
REQ-025 SHALL cover this case: FIPS-197 round-1 state input 0x19,0x3d,0xe3,0xbe,0xa0,0xf4,0xe2,0x2b,0x9a,0xc6,0x8d,0x2a,0xe9,0xf8,0x48,0x08, contiguous -> output 0x19,0xf4,0x8d,0x08,0xa0,0xc6,0x48,0xbe,0x9a,0xf8,0xe3,0x2b,0xe9,0x3d,0xe2,0x2a; out_valid rises 1 cycle after byte 15 is captured.
REQ-026 SHALL cover this case: input 0x00..0x0F -> output 0x00,0x05,0x0A,0x0F,0x04,0x09,0x0E,0x03,0x08,0x0D,0x02,0x07,0x0C,0x01,0x06,0x0B; out_last only with 0x0B.
REQ-027 SHALL cover this case: three back-to-back blocks, no in_valid gaps -> 48 consecutive out_valid cycles with correct data; out_last every 16th cycle.
REQ-028 SHALL cover this case: random in_valid gaps (~50% duty) -> output identical to the contiguous case; each block is output in 16 consecutive cycles.
REQ-029 SHALL cover this case: clear after 7 bytes, then a full block 0x00..0x0F -> only the 0x00..0x0F result appears; clear together with in_valid drops that byte.
REQ-030 SHALL cover this case: reset asserted mid-stream (output byte 6) -> out_valid=0 immediately, without waiting for a clock edge; the next full block produces correct output.
